// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the elastic pipeline-stage
//               buffer. It defines the control FSM state encoding, the
//               occupancy encodings and the NOP bubble bit. A bubble is an
//               all-zero payload word.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [1:0] c_occ_none = 2'd0;
   localparam logic [1:0] c_occ_one  = 2'd1;
   localparam logic [1:0] c_occ_two  = 2'd2;

   // Replicated to the payload width wherever a bubble word is needed.
   localparam logic c_nop_bit = 1'b0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One payload entry: a W-bit data register with a valid flag.
//               Clear has priority over load, and clear writes the NOP
//               bubble so a freed entry never leaks stale data.
// Ports       : clk   in  clock
//               rst   in  asynchronous active-high reset
//               load  in  capture d, mark valid
//               clear in  zero the entry, mark invalid
//               d     in  W-bit payload
//               q     out W-bit stored payload
//               valid out entry holds a live payload
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         valid
);

   logic [W-1:0] r_data;
   logic         r_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= {W{c_nop_bit}};
         r_valid <= 1'b0;
      end else if (clear) begin
         r_data  <= {W{c_nop_bit}};
         r_valid <= 1'b0;
      end else if (load) begin
         r_data  <= d;
         r_valid <= 1'b1;
      end
   end

   assign q     = r_data;
   assign valid = r_valid;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Elastic pipeline-stage buffer with a ready/valid handshake on
//               both sides. It has an optional skid entry that registers
//               in_ready, OR-combined flush inputs, and a saturating stall
//               counter.
// Ports       : clk          in  clock
//               rst          in  asynchronous active-high reset
//               in_valid     in  upstream offers in_data
//               in_ready     out stage accepts this cycle
//               in_data      in  W-bit payload
//               flush        in  NCLR flush sources, any high squashes stage
//               out_valid    out main entry holds a live payload
//               out_ready    in  downstream consumes this cycle
//               out_data     out main entry payload (zero when not valid)
//               occupancy    out live entries 0..2
//               stall_cycles out saturating count of stalled output cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int W    = 32,
   parameter int NCLR = 2,
   parameter int SKID = 1,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    in_data,
   input  logic [NCLR-1:0] flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_data,
   output logic [1:0]      occupancy,
   output logic [CNTW-1:0] stall_cycles
);

   localparam logic [CNTW-1:0] c_stall_max = {CNTW{1'b1}};
   localparam logic [CNTW-1:0] c_stall_one = {{(CNTW-1){1'b0}}, 1'b1};

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_flush_any;
   logic            w_in_fire;
   logic            w_out_fire;

   logic            w_main_load;
   logic            w_main_clear;
   logic            w_main_from_skid;
   logic [W-1:0]    w_main_d;
   logic [W-1:0]    w_main_q;
   logic            w_main_valid;

   logic            w_skid_load;
   logic            w_skid_clear;
   logic [W-1:0]    w_skid_q;
   logic            w_skid_valid;

   logic [CNTW-1:0] r_stall;

   assign w_flush_any = |flush;
   assign w_in_fire   = in_valid & in_ready;
   assign w_out_fire  = out_valid & out_ready;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_main_load      = 1'b0;
      w_main_clear     = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
      w_skid_clear     = 1'b0;

      if (w_flush_any) begin
         // Flush beats every other event. Input is already blocked because
         // in_ready is low. A same-cycle out_fire was taken downstream anyway.
         w_state_nxt  = ST_EMPTY;
         w_main_clear = 1'b1;
         w_skid_clear = 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt = ST_ONE;
                  w_main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_main_load = 1'b1;
               end else if (w_in_fire && (SKID != 0)) begin
                  // Downstream stalled: park the new word in the skid entry.
                  w_state_nxt = ST_TWO;
                  w_skid_load = 1'b1;
               end else if (w_out_fire) begin
                  w_state_nxt  = ST_EMPTY;
                  w_main_clear = 1'b1;
               end
            end
            ST_TWO: begin
               if (w_out_fire) begin
                  w_state_nxt      = ST_ONE;
                  w_main_load      = 1'b1;
                  w_main_from_skid = 1'b1;
                  w_skid_clear     = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

   pipe_slot #(
      .W (W)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (w_main_load),
      .clear (w_main_clear),
      .d     (w_main_d),
      .q     (w_main_q),
      .valid (w_main_valid)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_slot #(
            .W (W)
         ) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (w_skid_load),
            .clear (w_skid_clear),
            .d     (in_data),
            .q     (w_skid_q),
            .valid (w_skid_valid)
         );

         // Depends only on registered state, so upstream sees no
         // combinational path from out_ready.
         assign in_ready = (r_state != ST_TWO) & ~w_flush_any;
      end else begin : g_no_skid
         assign w_skid_q     = {W{c_nop_bit}};
         assign w_skid_valid = 1'b0;
         assign in_ready     = ((r_state == ST_EMPTY) | out_ready) & ~w_flush_any;
      end
   endgenerate

   assign out_valid = w_main_valid;
   assign out_data  = w_main_q;

   always_comb begin
      case ({w_main_valid, w_skid_valid})
         2'b11:   occupancy = c_occ_two;
         2'b10:   occupancy = c_occ_one;
         default: occupancy = c_occ_none;
      endcase
   end

   // ------------------------------------------------------------------------
   // Stall counter: flush does not clear it, only reset does
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall <= {CNTW{1'b0}};
      end else if (out_valid && !out_ready && (r_stall != c_stall_max)) begin
         r_stall <= r_stall + c_stall_one;
      end
   end

   assign stall_cycles = r_stall;

endmodule : pipe_stage_buf
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buf
// Description : Scoreboard bench for pipe_stage_buf. Instance a uses the
//               defaults (SKID=1, CNTW=16). Instance b uses SKID=0, CNTW=4.
//               Drivers push each accepted word into a queue. Monitors pop
//               and compare on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0] a_in_data, a_out_data;
   logic [1:0]  a_flush, a_occ;
   logic [15:0] a_stall;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_data, b_out_data;
   logic [1:0]  b_flush, b_occ;
   logic [3:0]  b_stall;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] a_q[$];
   logic [31:0] b_q[$];
   bit          toggling = 1'b0;
   logic [31:0] rnd;

   always #5 clk = ~clk;

   pipe_stage_buf #(.W(32), .NCLR(2), .SKID(1), .CNTW(16)) dut_a (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (a_in_valid),
      .in_ready     (a_in_ready),
      .in_data      (a_in_data),
      .flush        (a_flush),
      .out_valid    (a_out_valid),
      .out_ready    (a_out_ready),
      .out_data     (a_out_data),
      .occupancy    (a_occ),
      .stall_cycles (a_stall)
   );

   pipe_stage_buf #(.W(32), .NCLR(2), .SKID(0), .CNTW(4)) dut_b (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (b_in_valid),
      .in_ready     (b_in_ready),
      .in_data      (b_in_data),
      .flush        (b_flush),
      .out_valid    (b_out_valid),
      .out_ready    (b_out_ready),
      .out_data     (b_out_data),
      .occupancy    (b_occ),
      .stall_cycles (b_stall)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_extra: got %0h expected no output", a_out_data);
            end else begin
               check("a_order", a_out_data, a_q.pop_front());
            end
         end
         if (!a_out_valid) check("a_bubble", a_out_data, 32'h0);
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_extra: got %0h expected no output", b_out_data);
            end else begin
               check("b_order", b_out_data, b_q.pop_front());
            end
         end
         if (!b_out_valid) check("b_bubble", b_out_data, 32'h0);
         if (b_occ == 2'd1) check("b_mirror", {31'h0, b_in_ready}, {31'h0, b_out_ready});
      end
   end

   // ---------------- drivers ----------------
   task automatic a_send(input logic [31:0] data);
      bit ok = 1'b0;
      a_in_valid = 1'b1;
      a_in_data  = data;
      for (int n = 0; n < 10 && !ok; n++) begin
         @(negedge clk);
         if (a_in_ready) begin
            a_q.push_back(data);
            ok = 1'b1;
         end
         tick();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL a_accept_timeout: got no accept expected accept of %0h", data);
      end
   endtask

   task automatic b_send(input logic [31:0] data);
      bit ok = 1'b0;
      b_in_valid = 1'b1;
      b_in_data  = data;
      for (int n = 0; n < 10 && !ok; n++) begin
         @(negedge clk);
         if (b_in_ready) begin
            b_q.push_back(data);
            ok = 1'b1;
         end
         tick();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL b_accept_timeout: got no accept expected accept of %0h", data);
      end
   endtask

   task automatic a_drain();
      for (int n = 0; n < 30 && a_q.size() != 0; n++) tick();
      check("a_drain", a_q.size(), 32'd0);
   endtask

   task automatic b_drain();
      for (int n = 0; n < 30 && b_q.size() != 0; n++) tick();
      check("b_drain", b_q.size(), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst        = 1'b1;
      a_in_valid = 1'b0; a_in_data = 32'h0; a_flush = 2'b00; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = 32'h0; b_flush = 2'b00; b_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_out_valid", a_out_valid, 32'd0);
      check("rst_out_data", a_out_data, 32'd0);
      check("rst_occ", a_occ, 32'd0);
      check("rst_stall", a_stall, 32'd0);
      check("rst_in_ready_a", a_in_ready, 32'd1);
      check("rst_in_ready_b", b_in_ready, 32'd1);

      // Streaming 1..8 back-to-back
      a_out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         a_send(i);
         check("stream_valid", a_out_valid, 32'd1);
         check("stream_data", a_out_data, i);
      end
      a_in_valid = 1'b0;
      tick();
      check("stream_empty", a_out_valid, 32'd0);
      a_drain();

      // Backpressure: A held, B into skid, C held off
      a_out_ready = 1'b0;
      a_send(32'hA);
      a_send(32'hB);
      check("bp_occ2", a_occ, 32'd2);
      check("bp_in_ready", a_in_ready, 32'd0);
      check("bp_head", a_out_data, 32'hA);
      a_in_data = 32'hC;
      tick();
      check("bp_hold_occ", a_occ, 32'd2);
      check("bp_stall", a_stall, 32'd2);
      a_out_ready = 1'b1;
      a_send(32'hC);
      a_in_valid = 1'b0;
      a_drain();
      check("bp_stall_after", a_stall, 32'd2);

      // Flush from each source with the stage full
      for (int f = 0; f < 2; f++) begin
         a_out_ready = 1'b0;
         a_send(32'h11 + f);
         a_send(32'h21 + f);
         check("fl_pre_occ", a_occ, 32'd2);
         a_in_data  = 32'hD;
         a_in_valid = 1'b1;
         a_flush    = (f == 0) ? 2'b10 : 2'b01;
         @(negedge clk);
         check("fl_in_ready", a_in_ready, 32'd0);
         @(posedge clk);
         #1;
         a_flush    = 2'b00;
         a_in_valid = 1'b0;
         a_q.delete();
         check("fl_occ", a_occ, 32'd0);
         check("fl_valid", a_out_valid, 32'd0);
         check("fl_data", a_out_data, 32'd0);
         tick();
         check("fl_no_d", a_out_valid, 32'd0);
      end

      // Async reset with two entries live
      a_out_ready = 1'b0;
      a_send(32'h31);
      a_send(32'h32);
      a_in_valid = 1'b0;
      check("ar_pre_occ", a_occ, 32'd2);
      #3 rst = 1'b1;
      #1;
      check("ar_valid", a_out_valid, 32'd0);
      check("ar_data", a_out_data, 32'd0);
      check("ar_occ", a_occ, 32'd0);
      check("ar_stall", a_stall, 32'd0);
      a_q.delete();
      b_q.delete();
      tick();
      rst = 1'b0;
      check("ar_in_ready", a_in_ready, 32'd1);

      // SKID=0 with out_ready toggling every cycle, 100 payloads
      toggling = 1'b1;
      fork
         begin
            while (toggling) begin
               tick();
               b_out_ready = ~b_out_ready;
            end
         end
         begin
            for (int k = 0; k < 100; k++) begin
               rnd = $urandom;
               b_send(rnd);
            end
            b_in_valid = 1'b0;
            b_drain();
            toggling = 1'b0;
         end
      join

      // Saturation on CNTW=4 after a fresh reset
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b_q.delete();
      check("sat_rst", b_stall, 32'd0);
      b_out_ready = 1'b0;
      b_send(32'h55);
      b_in_valid = 1'b0;
      repeat (5) tick();
      check("sat_5", b_stall, 32'd5);
      repeat (15) tick();
      check("sat_15", b_stall, 32'd15);
      b_out_ready = 1'b1;
      b_drain();
      check("sat_keep", b_stall, 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipe_stage_buf
`default_nettype wire

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage buffer for the MIPS-5 datapath, the general replacement for the fixed per-stage latches (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries an arbitrary-width payload with a valid bit and a ready/valid handshake on both sides. It supports an optional one-entry skid slot that breaks the combinational ready path, and OR-combines any number of flush sources. A saturating stall counter supports performance debug.

## Interface
- W, default 32: payload width in bits; the stage packs pc_4, instruction, operands and control into this bus.
- NCLR, default 2: number of independent flush inputs.
- SKID, default 1: 1 = two entries (main + skid), registered in_ready; 0 = single entry, in_ready combinational from out_ready.
- CNTW, default 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage accepts this cycle.
- in_data  in  W  payload.
- flush  in  NCLR  any bit high squashes the whole stage.
- out_valid  out  1  main entry holds a live payload.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  W  main entry payload.
- occupancy  out  2  live entries (0, 1, 2).
- stall_cycles  out  CNTW  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- flush_any = |flush.
  - Forces in_ready=0 combinationally.
  - Wins over every other event at the edge.
- States: EMPTY, ONE, TWO (TWO only when SKID=1).
- EMPTY:
  - in_fire -> ONE; main <= in_data.
- ONE:
  - in_fire & out_fire -> ONE; main <= in_data.
  - in_fire & !out_fire -> TWO; skid <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- TWO:
  - out_fire -> ONE; main <= skid.
  - Otherwise hold.
  - in_ready=0 throughout TWO.
- in_ready:
  - SKID=1: (state != TWO) & !flush_any, registered-state only.
  - SKID=0: (state == EMPTY | out_ready) & !flush_any.
- Flush edge:
  - state <= EMPTY; main and skid data <= 0 (bubble = all-zero word, i.e. NOP).
  - Same-cycle input is dropped.
  - Same-cycle out_fire still counts as consumed downstream.
- Freed entries are zeroed; out_data = 0 whenever out_valid=0.
- Payload ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- stall_cycles:
  - Increments when out_valid & !out_ready; saturates at 2^CNTW-1.
  - Cleared only by rst; flush does not clear it.

## Timing
- Reset values:
  - state EMPTY; out_valid=0, out_data=0, occupancy=0, stall_cycles=0.
  - in_ready=1 once rst is low (if flush is low).
- Latency: accepted payload appears on out_data/out_valid the cycle after in_fire.
- Throughput: 1 payload/cycle while out_ready=1.
- SKID=1: absorbs exactly one extra payload after out_ready falls; in_ready drops the following cycle.
- rst asserted mid-transfer: outputs go to reset values immediately (async); in-flight payloads are lost.
- Simultaneous flush and rst: rst dominates; the result is identical.

## Structure
- Shared package pipe_pkg:
  - state enum {EMPTY, ONE, TWO};
  - occupancy encodings;
  - NOP bubble constant (all-zero).
- Sub-module pipe_slot: one W-bit data register plus valid bit, with load, clear (zero) and async reset.
  - Instantiated twice (main, skid); skid is generated only when SKID=1.
- Control FSM and stall counter live in pipe_stage_buf.

## Test plan
- Reset: assert rst mid-stream with occupancy=2 -> out_valid=0, out_data=0, occupancy=0 and stall_cycles=0 asynchronously. After release with flush=0, in_ready=1.
- Streaming, W=32, SKID=1: push 0x1..0x8 back-to-back with out_ready=1 -> out_data shows 0x1..0x8 on consecutive cycles, one cycle after each accept.
- Backpressure: out_ready=0 after accepting 0xA, then offer 0xB, 0xC:
  - 0xB is accepted into skid; occupancy=2, in_ready=0, 0xC is held.
  - After out_ready=1, output order is 0xA, 0xB, 0xC.
  - stall_cycles equals the number of cycles out_ready was held low.
- Flush, NCLR=2: with occupancy=2, pulse flush=2'b10 while offering 0xD -> next cycle occupancy=0, out_data=0, 0xD not accepted. Repeat with flush=2'b01 and get the same result.
- SKID=0: out_ready toggles every cycle -> in_ready mirrors out_ready when ONE; no payload is lost or duplicated over 100 random payloads.
- Saturation: CNTW=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cycles stops at 15.
